// File: rtl/id_ex_lanes.sv
// ID/EX pipeline register for an N-lane issue core.
// Handles partial-keep flush, stall bubble/hold, and saturating bubble/flush event counters.
module id_ex_lanes #(
   parameter int LANES  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int OP_W   = 8,
   parameter int SEL_W  = 3,
   parameter int RA_W   = 5,
   parameter int CORR_W = 34,
   parameter int CNT_W  = 16,
   localparam int KW    = $clog2(LANES + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall_id,
   input  logic                     stall_ex,
   input  logic                     flush,
   input  logic [KW-1:0]            flush_keep,
   input  logic [LANES-1:0]         valid_i,
   input  logic [LANES*ADDR_W-1:0]  pc_i,
   input  logic [LANES*CORR_W-1:0]  corr_i,
   input  logic [LANES*OP_W-1:0]    aluop_i,
   input  logic [LANES*SEL_W-1:0]   alusel_i,
   input  logic [LANES*DATA_W-1:0]  src1_i,
   input  logic [LANES*DATA_W-1:0]  src2_i,
   input  logic [LANES*RA_W-1:0]    waddr_i,
   input  logic [LANES-1:0]         we_i,
   input  logic [LANES-1:0]         dslot_i,
   input  logic [DATA_W-1:0]        hi_i,
   input  logic [DATA_W-1:0]        lo_i,
   input  logic                     imm_fnl_i,
   input  logic                     next_dslot_i,
   output logic [LANES-1:0]         valid_o,
   output logic [LANES*ADDR_W-1:0]  pc_o,
   output logic [LANES*CORR_W-1:0]  corr_o,
   output logic [LANES*OP_W-1:0]    aluop_o,
   output logic [LANES*SEL_W-1:0]   alusel_o,
   output logic [LANES*DATA_W-1:0]  src1_o,
   output logic [LANES*DATA_W-1:0]  src2_o,
   output logic [LANES*RA_W-1:0]    waddr_o,
   output logic [LANES-1:0]         we_o,
   output logic [LANES-1:0]         dslot_o,
   output logic [DATA_W-1:0]        hi_o,
   output logic [DATA_W-1:0]        lo_o,
   output logic                     imm_fnl_o,
   output logic                     next_dslot_o,
   output logic [KW-1:0]            lane_cnt_o,
   output logic [CNT_W-1:0]         bubble_cnt_o,
   output logic [CNT_W-1:0]         flush_cnt_o
);

   logic [LANES-1:0] lane_ld;
   logic [LANES-1:0] lane_bub;
   logic [LANES-1:0] valid_nxt;
   logic [KW-1:0]    lane_cnt_nxt;
   logic             sh_ld;
   logic             sh_clr;
   logic             nd_ld;
   logic             bub_evt;
   int               keep;

   assign bub_evt = stall_id && !stall_ex && !flush;

   // Decide per lane whether it loads, becomes a bubble, or holds this cycle.
   always_comb begin
      lane_ld      = '0;
      lane_bub     = '0;
      sh_ld        = 1'b0;
      sh_clr       = 1'b0;
      nd_ld        = 1'b0;
      valid_nxt    = '0;
      lane_cnt_nxt = '0;
      keep         = (int'(flush_keep) > LANES) ? LANES : int'(flush_keep);
      if (flush) begin
         for (int i = 0; i < LANES; i++) begin
            lane_ld[i] = (i < keep);
         end
         lane_bub = ~lane_ld;
         sh_ld    = (keep != 0);
         sh_clr   = (keep == 0);
      end else if (stall_id && !stall_ex) begin
         lane_bub = '1;
         sh_clr   = 1'b1;
      end else if (!stall_id) begin
         lane_ld = '1;
         sh_ld   = 1'b1;
         nd_ld   = 1'b1;
      end
      for (int i = 0; i < LANES; i++) begin
         valid_nxt[i] = lane_ld[i] ? valid_i[i] : (lane_bub[i] ? 1'b0 : valid_o[i]);
         lane_cnt_nxt = lane_cnt_nxt + KW'(valid_nxt[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_o      <= '0;
         pc_o         <= '0;
         corr_o       <= '0;
         aluop_o      <= '0;
         alusel_o     <= '0;
         src1_o       <= '0;
         src2_o       <= '0;
         waddr_o      <= '0;
         we_o         <= '0;
         dslot_o      <= '0;
         hi_o         <= '0;
         lo_o         <= '0;
         imm_fnl_o    <= 1'b0;
         next_dslot_o <= 1'b0;
         lane_cnt_o   <= '0;
         bubble_cnt_o <= '0;
         flush_cnt_o  <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (lane_ld[i]) begin
               pc_o[i*ADDR_W +: ADDR_W]    <= pc_i[i*ADDR_W +: ADDR_W];
               corr_o[i*CORR_W +: CORR_W]  <= corr_i[i*CORR_W +: CORR_W];
               aluop_o[i*OP_W +: OP_W]     <= aluop_i[i*OP_W +: OP_W];
               alusel_o[i*SEL_W +: SEL_W]  <= alusel_i[i*SEL_W +: SEL_W];
               src1_o[i*DATA_W +: DATA_W]  <= src1_i[i*DATA_W +: DATA_W];
               src2_o[i*DATA_W +: DATA_W]  <= src2_i[i*DATA_W +: DATA_W];
               waddr_o[i*RA_W +: RA_W]     <= waddr_i[i*RA_W +: RA_W];
               we_o[i]                     <= we_i[i];
               dslot_o[i]                  <= dslot_i[i];
            end else if (lane_bub[i]) begin
               pc_o[i*ADDR_W +: ADDR_W]    <= '0;
               corr_o[i*CORR_W +: CORR_W]  <= '0;
               aluop_o[i*OP_W +: OP_W]     <= '0;
               alusel_o[i*SEL_W +: SEL_W]  <= '0;
               src1_o[i*DATA_W +: DATA_W]  <= '0;
               src2_o[i*DATA_W +: DATA_W]  <= '0;
               waddr_o[i*RA_W +: RA_W]     <= '0;
               we_o[i]                     <= 1'b0;
               dslot_o[i]                  <= 1'b0;
            end
         end
         valid_o    <= valid_nxt;
         lane_cnt_o <= lane_cnt_nxt;
         if (sh_ld) begin
            hi_o      <= hi_i;
            lo_o      <= lo_i;
            imm_fnl_o <= imm_fnl_i;
         end else if (sh_clr) begin
            hi_o      <= '0;
            lo_o      <= '0;
            imm_fnl_o <= 1'b0;
         end
         // next_dslot only advances on a real load; flush and bubble keep it.
         if (nd_ld) next_dslot_o <= next_dslot_i;
         if (flush && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
         if (bub_evt && bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_ex_lanes.sv
// Bench for id_ex_lanes: a dual-lane instance against a reference model and scoreboard,
// plus a 4-lane, 4-bit-counter instance for keep clamping and counter saturation.
module tb_id_ex_lanes;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- dual-lane instance ----------------
   logic        a_rst, a_stall_id, a_stall_ex, a_flush;
   logic [1:0]  a_flush_keep, a_valid_i, a_we_i, a_dslot_i;
   logic [63:0] a_pc_i, a_src1_i, a_src2_i;
   logic [67:0] a_corr_i;
   logic [15:0] a_aluop_i;
   logic [5:0]  a_alusel_i;
   logic [9:0]  a_waddr_i;
   logic [31:0] a_hi_i, a_lo_i;
   logic        a_imm_i, a_nd_i;
   logic [1:0]  a_valid_o, a_we_o, a_dslot_o, a_lane_cnt_o;
   logic [63:0] a_pc_o, a_src1_o, a_src2_o;
   logic [67:0] a_corr_o;
   logic [15:0] a_aluop_o, a_bubble_cnt_o, a_flush_cnt_o;
   logic [5:0]  a_alusel_o;
   logic [9:0]  a_waddr_o;
   logic [31:0] a_hi_o, a_lo_o;
   logic        a_imm_o, a_nd_o;

   id_ex_lanes dut2 (
      .clk(clk), .rst(a_rst), .stall_id(a_stall_id), .stall_ex(a_stall_ex),
      .flush(a_flush), .flush_keep(a_flush_keep), .valid_i(a_valid_i), .pc_i(a_pc_i),
      .corr_i(a_corr_i), .aluop_i(a_aluop_i), .alusel_i(a_alusel_i), .src1_i(a_src1_i),
      .src2_i(a_src2_i), .waddr_i(a_waddr_i), .we_i(a_we_i), .dslot_i(a_dslot_i),
      .hi_i(a_hi_i), .lo_i(a_lo_i), .imm_fnl_i(a_imm_i), .next_dslot_i(a_nd_i),
      .valid_o(a_valid_o), .pc_o(a_pc_o), .corr_o(a_corr_o), .aluop_o(a_aluop_o),
      .alusel_o(a_alusel_o), .src1_o(a_src1_o), .src2_o(a_src2_o), .waddr_o(a_waddr_o),
      .we_o(a_we_o), .dslot_o(a_dslot_o), .hi_o(a_hi_o), .lo_o(a_lo_o),
      .imm_fnl_o(a_imm_o), .next_dslot_o(a_nd_o), .lane_cnt_o(a_lane_cnt_o),
      .bubble_cnt_o(a_bubble_cnt_o), .flush_cnt_o(a_flush_cnt_o)
   );

   // ---------------- 4-lane instance ----------------
   logic         b_rst, b_stall_id, b_stall_ex, b_flush;
   logic [2:0]   b_flush_keep, b_lane_cnt_o;
   logic [3:0]   b_valid_i, b_we_i, b_dslot_i, b_valid_o, b_we_o, b_dslot_o;
   logic [127:0] b_pc_i, b_src1_i, b_src2_i, b_pc_o, b_src1_o, b_src2_o;
   logic [135:0] b_corr_i, b_corr_o;
   logic [31:0]  b_aluop_i, b_aluop_o, b_hi_i, b_lo_i, b_hi_o, b_lo_o;
   logic [11:0]  b_alusel_i, b_alusel_o;
   logic [19:0]  b_waddr_i, b_waddr_o;
   logic         b_imm_i, b_nd_i, b_imm_o, b_nd_o;
   logic [3:0]   b_bubble_cnt_o, b_flush_cnt_o;

   id_ex_lanes #(.LANES(4), .CNT_W(4)) dut4 (
      .clk(clk), .rst(b_rst), .stall_id(b_stall_id), .stall_ex(b_stall_ex),
      .flush(b_flush), .flush_keep(b_flush_keep), .valid_i(b_valid_i), .pc_i(b_pc_i),
      .corr_i(b_corr_i), .aluop_i(b_aluop_i), .alusel_i(b_alusel_i), .src1_i(b_src1_i),
      .src2_i(b_src2_i), .waddr_i(b_waddr_i), .we_i(b_we_i), .dslot_i(b_dslot_i),
      .hi_i(b_hi_i), .lo_i(b_lo_i), .imm_fnl_i(b_imm_i), .next_dslot_i(b_nd_i),
      .valid_o(b_valid_o), .pc_o(b_pc_o), .corr_o(b_corr_o), .aluop_o(b_aluop_o),
      .alusel_o(b_alusel_o), .src1_o(b_src1_o), .src2_o(b_src2_o), .waddr_o(b_waddr_o),
      .we_o(b_we_o), .dslot_o(b_dslot_o), .hi_o(b_hi_o), .lo_o(b_lo_o),
      .imm_fnl_o(b_imm_o), .next_dslot_o(b_nd_o), .lane_cnt_o(b_lane_cnt_o),
      .bubble_cnt_o(b_bubble_cnt_o), .flush_cnt_o(b_flush_cnt_o)
   );

   // ---------------- reference model and scoreboard (dual-lane) ----------------
   typedef struct packed {
      logic [1:0]  valid;
      logic [63:0] pc;
      logic [67:0] corr;
      logic [15:0] aluop;
      logic [5:0]  alusel;
      logic [63:0] src1;
      logic [63:0] src2;
      logic [9:0]  waddr;
      logic [1:0]  we;
      logic [1:0]  dslot;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        imm;
      logic        nd;
      logic [1:0]  lcnt;
      logic [15:0] bcnt;
      logic [15:0] fcnt;
   } st_t;
   localparam int SW = $bits(st_t);

   logic [SW-1:0] exp_q[$];
   st_t m = '0;
   st_t obs;
   assign obs = {a_valid_o, a_pc_o, a_corr_o, a_aluop_o, a_alusel_o, a_src1_o, a_src2_o,
                 a_waddr_o, a_we_o, a_dslot_o, a_hi_o, a_lo_o, a_imm_o, a_nd_o,
                 a_lane_cnt_o, a_bubble_cnt_o, a_flush_cnt_o};

   function automatic st_t take_lane(st_t s, int l, bit fill);
      st_t n = s;
      n.valid[l]          = fill ? a_valid_i[l] : 1'b0;
      n.pc[l*32 +: 32]    = fill ? a_pc_i[l*32 +: 32] : 32'h0;
      n.corr[l*34 +: 34]  = fill ? a_corr_i[l*34 +: 34] : 34'h0;
      n.aluop[l*8 +: 8]   = fill ? a_aluop_i[l*8 +: 8] : 8'h0;
      n.alusel[l*3 +: 3]  = fill ? a_alusel_i[l*3 +: 3] : 3'h0;
      n.src1[l*32 +: 32]  = fill ? a_src1_i[l*32 +: 32] : 32'h0;
      n.src2[l*32 +: 32]  = fill ? a_src2_i[l*32 +: 32] : 32'h0;
      n.waddr[l*5 +: 5]   = fill ? a_waddr_i[l*5 +: 5] : 5'h0;
      n.we[l]             = fill ? a_we_i[l] : 1'b0;
      n.dslot[l]          = fill ? a_dslot_i[l] : 1'b0;
      return n;
   endfunction

   function automatic st_t model_next(st_t s);
      st_t n = s;
      int k;
      if (a_rst) return '0;
      if (a_flush) begin
         k = (a_flush_keep > 2'd2) ? 2 : int'(a_flush_keep);
         for (int l = 0; l < 2; l++) n = take_lane(n, l, l < k);
         n.hi  = (k > 0) ? a_hi_i : 32'h0;
         n.lo  = (k > 0) ? a_lo_i : 32'h0;
         n.imm = (k > 0) ? a_imm_i : 1'b0;
         if (n.fcnt != 16'hFFFF) n.fcnt = n.fcnt + 16'd1;
      end else if (a_stall_id && !a_stall_ex) begin
         for (int l = 0; l < 2; l++) n = take_lane(n, l, 1'b0);
         n.hi = 32'h0; n.lo = 32'h0; n.imm = 1'b0;
         if (n.bcnt != 16'hFFFF) n.bcnt = n.bcnt + 16'd1;
      end else if (!a_stall_id) begin
         for (int l = 0; l < 2; l++) n = take_lane(n, l, 1'b1);
         n.hi = a_hi_i; n.lo = a_lo_i; n.imm = a_imm_i; n.nd = a_nd_i;
      end
      n.lcnt = {1'b0, n.valid[0]} + {1'b0, n.valid[1]};
      return n;
   endfunction

   // Scoreboard: one expected state per edge, compared 1 time unit after the edge.
   always @(posedge clk) begin
      st_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL state: got %h want %h", obs, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      m = model_next(m);
      exp_q.push_back(m);
      @(posedge clk);
      #2;
   endtask

   task automatic rand_a_inputs();
      logic [95:0] r;
      a_valid_i  = 2'($urandom_range(0, 3));
      a_pc_i     = {$urandom(), $urandom()};
      r          = {$urandom(), $urandom(), $urandom()};
      a_corr_i   = r[67:0];
      a_aluop_i  = 16'($urandom());
      a_alusel_i = 6'($urandom());
      a_src1_i   = {$urandom(), $urandom()};
      a_src2_i   = {$urandom(), $urandom()};
      a_waddr_i  = 10'($urandom());
      a_we_i     = 2'($urandom());
      a_dslot_i  = 2'($urandom());
      a_hi_i     = $urandom();
      a_lo_i     = $urandom();
      a_imm_i    = 1'($urandom());
      a_nd_i     = 1'($urandom());
   endtask

   task automatic a_ctrl(input logic sid, input logic sex, input logic fl, input logic [1:0] k);
      a_stall_id = sid; a_stall_ex = sex; a_flush = fl; a_flush_keep = k;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         rand_a_inputs();
         a_ctrl(1'($urandom()), 1'($urandom()), 1'($urandom()), 2'($urandom()));
         tick();
      end
      n_cmp++; if (a_valid_o !== 2'b00) begin n_err++; $display("FAIL rst_valid: got %b want 00", a_valid_o); end
      n_cmp++; if (a_pc_o !== 64'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", a_pc_o); end
      n_cmp++; if (a_flush_cnt_o !== 16'h0 || a_bubble_cnt_o !== 16'h0) begin
         n_err++; $display("FAIL rst_cnt: got %h/%h want 0/0", a_flush_cnt_o, a_bubble_cnt_o);
      end
      a_rst = 1'b0; b_rst = 1'b0;
      a_ctrl(1'b0, 1'b0, 1'b0, 2'd0);
      rand_a_inputs();
      a_valid_i = 2'b11;
      a_pc_i    = {32'hBFC00004, 32'hBFC00000};
      tick();
      n_cmp++; if (a_valid_o !== 2'b11) begin n_err++; $display("FAIL first_valid: got %b want 11", a_valid_o); end
      n_cmp++; if (a_pc_o !== 64'hBFC00004_BFC00000) begin n_err++; $display("FAIL first_pc: got %h want bfc00004bfc00000", a_pc_o); end
      n_cmp++; if (a_lane_cnt_o !== 2'd2) begin n_err++; $display("FAIL first_lcnt: got %0d want 2", a_lane_cnt_o); end
   endtask

   task automatic test_partial_flush();
      rand_a_inputs();
      a_valid_i         = 2'b11;
      a_pc_i[31:0]      = 32'h80001000;
      a_we_i            = 2'b11;
      a_waddr_i         = {5'd9, 5'd5};
      a_aluop_i[15:8]   = 8'h21;
      a_ctrl(1'b0, 1'b0, 1'b1, 2'd1);
      tick();
      n_cmp++; if (a_valid_o !== 2'b01) begin n_err++; $display("FAIL pflush_valid: got %b want 01", a_valid_o); end
      n_cmp++; if (a_pc_o !== {32'h0, 32'h80001000}) begin n_err++; $display("FAIL pflush_pc: got %h want 0000000080001000", a_pc_o); end
      n_cmp++; if (a_we_o !== 2'b01) begin n_err++; $display("FAIL pflush_we: got %b want 01", a_we_o); end
      n_cmp++; if (a_waddr_o !== {5'd0, 5'd5}) begin n_err++; $display("FAIL pflush_waddr: got %h want 005", a_waddr_o); end
      n_cmp++; if (a_aluop_o[15:8] !== 8'h0) begin n_err++; $display("FAIL pflush_aluop1: got %h want 00", a_aluop_o[15:8]); end
      n_cmp++; if (a_flush_cnt_o !== 16'd1) begin n_err++; $display("FAIL pflush_cnt: got %0d want 1", a_flush_cnt_o); end
      a_ctrl(1'b0, 1'b0, 1'b0, 2'd0);
   endtask

   task automatic test_full_flush();
      rand_a_inputs();
      a_nd_i = 1'b1;
      tick();
      rand_a_inputs();
      a_nd_i = 1'b0;
      a_ctrl(1'b1, 1'b1, 1'b1, 2'd0);
      tick();
      n_cmp++; if (a_valid_o !== 2'b00) begin n_err++; $display("FAIL fflush_valid: got %b want 00", a_valid_o); end
      n_cmp++; if (a_hi_o !== 32'h0 || a_lo_o !== 32'h0) begin n_err++; $display("FAIL fflush_hilo: got %h/%h want 0/0", a_hi_o, a_lo_o); end
      n_cmp++; if (a_nd_o !== 1'b1) begin n_err++; $display("FAIL fflush_nd: got %b want 1", a_nd_o); end
      n_cmp++; if (a_flush_cnt_o !== 16'd2) begin n_err++; $display("FAIL fflush_cnt: got %0d want 2", a_flush_cnt_o); end
      a_ctrl(1'b0, 1'b0, 1'b0, 2'd0);
   endtask

   task automatic test_clamp2();
      logic [31:0] hi_exp;
      rand_a_inputs();
      a_valid_i = 2'b11;
      hi_exp    = a_hi_i;
      a_ctrl(1'b0, 1'b0, 1'b1, 2'd3);
      tick();
      n_cmp++; if (a_valid_o !== 2'b11) begin n_err++; $display("FAIL clamp2_valid: got %b want 11", a_valid_o); end
      n_cmp++; if (a_lane_cnt_o !== 2'd2) begin n_err++; $display("FAIL clamp2_lcnt: got %0d want 2", a_lane_cnt_o); end
      n_cmp++; if (a_hi_o !== hi_exp) begin n_err++; $display("FAIL clamp2_hi: got %h want %h", a_hi_o, hi_exp); end
      a_ctrl(1'b0, 1'b0, 1'b0, 2'd0);
   endtask

   task automatic test_bubble_hold();
      a_ctrl(1'b1, 1'b0, 1'b0, 2'd0);
      rand_a_inputs();
      tick();
      rand_a_inputs();
      tick();
      n_cmp++; if (a_valid_o !== 2'b00) begin n_err++; $display("FAIL bub_valid: got %b want 00", a_valid_o); end
      n_cmp++; if (a_bubble_cnt_o !== 16'd2) begin n_err++; $display("FAIL bub_cnt: got %0d want 2", a_bubble_cnt_o); end
      n_cmp++; if (a_hi_o !== 32'h0) begin n_err++; $display("FAIL bub_hi: got %h want 0", a_hi_o); end
      a_ctrl(1'b0, 1'b0, 1'b0, 2'd0);
      rand_a_inputs();
      a_valid_i = 2'b11;
      a_pc_i    = {32'h104, 32'h100};
      tick();
      a_ctrl(1'b1, 1'b1, 1'b0, 2'd0);
      for (int c = 0; c < 3; c++) begin
         rand_a_inputs();
         tick();
         n_cmp++; if (a_pc_o !== {32'h104, 32'h100}) begin n_err++; $display("FAIL hold_pc%0d: got %h want 0000010400000100", c, a_pc_o); end
         n_cmp++; if (a_valid_o !== 2'b11) begin n_err++; $display("FAIL hold_valid%0d: got %b want 11", c, a_valid_o); end
      end
   endtask

   task automatic test_async_reset();
      #2;
      a_rst = 1'b1;
      #1;
      n_cmp++; if (a_valid_o !== 2'b00 || a_pc_o !== 64'h0) begin
         n_err++; $display("FAIL async_rst: got valid %b pc %h want 00/0", a_valid_o, a_pc_o);
      end
      n_cmp++; if (a_bubble_cnt_o !== 16'h0) begin n_err++; $display("FAIL async_rst_cnt: got %0d want 0", a_bubble_cnt_o); end
      tick();
      a_rst = 1'b0;
      a_ctrl(1'b0, 1'b0, 1'b0, 2'd0);
      rand_a_inputs();
      tick();
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 60; c++) begin
         rand_a_inputs();
         a_ctrl(1'($urandom_range(0, 2) == 0), 1'($urandom()),
                1'($urandom_range(0, 4) == 0), 2'($urandom()));
         tick();
      end
      a_ctrl(1'b0, 1'b0, 1'b0, 2'd0);
      tick();
   endtask

   task automatic test_clamp4();
      logic [127:0] pc_exp;
      b_pc_i       = {$urandom(), $urandom(), $urandom(), $urandom()};
      pc_exp       = b_pc_i;
      b_valid_i    = 4'b1011;
      b_flush      = 1'b1;
      b_flush_keep = 3'd5;
      tick();
      n_cmp++; if (b_valid_o !== 4'b1011) begin n_err++; $display("FAIL clamp4_valid: got %b want 1011", b_valid_o); end
      n_cmp++; if (b_lane_cnt_o !== 3'd3) begin n_err++; $display("FAIL clamp4_lcnt: got %0d want 3", b_lane_cnt_o); end
      n_cmp++; if (b_pc_o !== pc_exp) begin n_err++; $display("FAIL clamp4_pc: got %h want %h", b_pc_o, pc_exp); end
      n_cmp++; if (b_flush_cnt_o !== 4'd1) begin n_err++; $display("FAIL clamp4_fcnt: got %0d want 1", b_flush_cnt_o); end
      b_flush      = 1'b0;
      b_flush_keep = 3'd0;
   endtask

   task automatic test_saturation();
      logic [3:0] want;
      b_stall_id = 1'b1;
      b_stall_ex = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         want = (c > 15) ? 4'd15 : 4'(c);
         n_cmp++; if (b_bubble_cnt_o !== want) begin n_err++; $display("FAIL sat_cnt%0d: got %0d want %0d", c, b_bubble_cnt_o, want); end
      end
      n_cmp++; if (b_valid_o !== 4'b0000) begin n_err++; $display("FAIL sat_valid: got %b want 0000", b_valid_o); end
      b_stall_id = 1'b0;
   endtask

   initial begin
      a_rst = 1'b1; b_rst = 1'b1;
      a_ctrl(1'b0, 1'b0, 1'b0, 2'd0);
      rand_a_inputs();
      b_stall_id = 1'b0; b_stall_ex = 1'b0; b_flush = 1'b0; b_flush_keep = 3'd0;
      b_valid_i = '0; b_pc_i = '0; b_corr_i = '0; b_aluop_i = '0; b_alusel_i = '0;
      b_src1_i = '0; b_src2_i = '0; b_waddr_i = '0; b_we_i = '0; b_dslot_i = '0;
      b_hi_i = '0; b_lo_i = '0; b_imm_i = 1'b0; b_nd_i = 1'b0;
      test_reset();
      test_partial_flush();
      test_full_flush();
      test_clamp2();
      test_bubble_hold();
      test_async_reset();
      test_back_to_back();
      test_clamp4();
      test_saturation();
      #5;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/id_ex_lanes.md
Name: id_ex_lanes

Overview:
- Parametrised ID/EX pipeline register for an N-lane issue core; the default configuration is the current dual-issue machine.
- Captures the decoded per-lane payload and the shared payload from ID and presents them to EX.
- Adds explicit per-lane valid bits.
- Adds a partial-keep flush for branch misprediction: the leading K lanes survive and the rest become bubbles.
- Adds a stall-bubble/hold policy and a saturating bubble/flush event counter for performance analysis.

Parameters:
- LANES, 2, number of issue lanes (1..4).
- ADDR_W, 32, instruction address width.
- DATA_W, 32, operand / HI / LO width.
- OP_W, 8, aluop width.
- SEL_W, 3, alusel width.
- RA_W, 5, register address width.
- CORR_W, 34, branch-predictor correction packet width per lane.
- CNT_W, 16, event counter width.
- KW (localparam), $clog2(LANES+1), width of the keep count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- stall_id  in  1  ID stage stalled.
- stall_ex  in  1  EX stage stalled.
- flush  in  1  pipeline flush request.
- flush_keep  in  KW  number of leading input lanes to capture on flush (0 = flush all).
- valid_i  in  LANES  per-lane valid from ID.
- pc_i  in  LANES*ADDR_W  per-lane instruction address; lane i at [i*ADDR_W +: ADDR_W].
- corr_i  in  LANES*CORR_W  per-lane predictor correction packet.
- aluop_i  in  LANES*OP_W  per-lane aluop.
- alusel_i  in  LANES*SEL_W  per-lane alusel.
- src1_i  in  LANES*DATA_W  per-lane operand 1.
- src2_i  in  LANES*DATA_W  per-lane operand 2.
- waddr_i  in  LANES*RA_W  per-lane destination register.
- we_i  in  LANES  per-lane write enable.
- dslot_i  in  LANES  per-lane in-delay-slot flag.
- hi_i  in  DATA_W  shared HI.
- lo_i  in  DATA_W  shared LO.
- imm_fnl_i  in  1  shared immediate-final flag.
- next_dslot_i  in  1  next instruction is in a delay slot.
- Outputs: valid_o, pc_o, corr_o, aluop_o, alusel_o, src1_o, src2_o, waddr_o, we_o, dslot_o, hi_o, lo_o, imm_fnl_o, next_dslot_o; widths identical to the matching inputs; registered EX-side copies.
- lane_cnt_o  out  KW  popcount of valid_o (registered).
- bubble_cnt_o  out  CNT_W  saturating count of bubble-insert cycles.
- flush_cnt_o  out  CNT_W  saturating count of flush cycles.

Behaviour:
- All outputs are registers. Reset is asynchronous on rst high; every output goes to 0. The zero value means NOP aluop/alusel, waddr 0, we 0, valid 0, not-in-delay-slot, counters 0.
- Per-cycle priority, evaluated at the rising edge: rst > flush > bubble > load > hold.
- Lane bubble: valid, we, dslot, pc, corr, src1, src2, waddr, aluop and alusel all become 0.
- FLUSH (flush=1), regardless of stalls:
  - Lanes i < flush_keep load their input fields. Their valid = valid_i[i].
  - Lanes i >= flush_keep are bubbles.
  - hi/lo/imm_fnl load from input when flush_keep > 0; otherwise they clear to 0.
  - next_dslot_o holds.
  - flush_keep > LANES is clamped to LANES.
  - flush_cnt increments.
- BUBBLE (stall_id=1, stall_ex=0):
  - All lanes become bubbles; hi/lo/imm_fnl clear to 0; next_dslot_o holds.
  - bubble_cnt increments.
- LOAD (stall_id=0): every field loads from its input, including next_dslot_o. stall_ex=1 with stall_id=0 is illegal upstream; the block treats it as LOAD.
- HOLD (stall_id=1, stall_ex=1): all registers keep their value.
- lane_cnt_o is computed from the next valid_o value and registered with it, so it always equals popcount(valid_o).
- Counters saturate at all-ones and never wrap.
- Latency: 1 cycle, input to output.
- Lane ordering: lane 0 is the oldest instruction; a kept prefix is always contiguous from lane 0.
- Reset asserted mid-stall or mid-flush forces zeros immediately (asynchronously). The first rising edge after rst falls performs a normal evaluation.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with random inputs → all outputs 0; deassert with stall_id=0, valid_i=2'b11, pc_i={0xBFC00004,0xBFC00000} → next edge valid_o=2'b11, pc_o matches, lane_cnt_o=2.
2. Partial flush: flush=1, flush_keep=1, lane0 pc=0x80001000, we=1, waddr=5; lane1 we=1 → valid_o=2'b01, lane0 fields captured, lane1 we=0, waddr=0, aluop=0; flush_cnt_o=1.
3. Full flush: flush=1, flush_keep=0 while stall_id=stall_ex=1 → valid_o=0, hi_o=lo_o=0, next_dslot_o unchanged; flush overrides the hold.
4. Bubble then hold: stall_id=1, stall_ex=0 for 2 cycles → valid_o=0, bubble_cnt_o=2. Then stall_id=stall_ex=1 after loading pc=0x100/0x104 → outputs frozen for 3 cycles.
5. Counter saturation: CNT_W=4, 20 consecutive bubble cycles → bubble_cnt_o stops at 15.
6. LANES=4, flush_keep=5 (clamped) with valid_i=4'b1011 → valid_o=4'b1011, lane_cnt_o=3.
